// File: rtl/score_pkg.sv
// Shared game-status codes and seven-segment constants
// for the score display and the game-state block.
package score_pkg;

  localparam logic [2:0] ST_PLAY = 3'd0;
  localparam logic [2:0] ST_XWIN = 3'd1;
  localparam logic [2:0] ST_OWIN = 3'd2;
  localparam logic [2:0] ST_DRAW = 3'd3;

  localparam int AN_W = 4;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    S_IDLE,
    S_ARMED
  } arm_t;

endpackage

// File: rtl/score_display_bcd_counter2.sv
// Two-digit BCD incrementer that saturates at 99.
// Used once for the X score and once for the O score.
module bcd_counter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       w_full;

  assign w_full = (r_tens == 4'd9) && (r_ones == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (inc && !w_full) begin
      if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign tens = r_tens;
  assign ones = r_ones;

endmodule

// File: rtl/score_display.sv
// Running X/O/draw tally with a multiplexed 4-digit
// seven-segment readout (X score left, O score right).
module score_display
  import score_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      game_status,
  output logic [6:0]      seg,
  output logic [AN_W-1:0] an,
  output logic            dp,
  output logic [7:0]      draws
);

  localparam int DW = $clog2(REFRESH_DIV);

  arm_t r_state;
  arm_t w_state_nxt;
  logic w_inc_x;
  logic w_inc_o;
  logic w_inc_d;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // One result per game: only a seen ST_PLAY re-arms counting
  always_comb begin
    w_state_nxt = r_state;
    w_inc_x     = 1'b0;
    w_inc_o     = 1'b0;
    w_inc_d     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (game_status == ST_PLAY)
          w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (game_status == ST_XWIN) begin
          w_inc_x     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (game_status == ST_OWIN) begin
          w_inc_o     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (game_status == ST_DRAW) begin
          w_inc_d     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  logic [3:0] w_x_tens;
  logic [3:0] w_x_ones;
  logic [3:0] w_o_tens;
  logic [3:0] w_o_ones;

  bcd_counter2 u_x (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_inc_x),
    .tens (w_x_tens),
    .ones (w_x_ones)
  );

  bcd_counter2 u_o (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_inc_o),
    .tens (w_o_tens),
    .ones (w_o_ones)
  );

  logic [7:0] r_draws;

  always_ff @(posedge clk) begin
    if (rst)
      r_draws <= 8'd0;
    else if (w_inc_d && (r_draws != 8'hFF))
      r_draws <= r_draws + 8'd1;
  end

  assign draws = r_draws;

  logic [DW-1:0]   r_div_cnt;
  logic [1:0]      r_sel;
  logic [AN_W-1:0] r_an;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic            w_wrap;
  logic [1:0]      w_sel_nxt;
  logic [3:0]      w_nib;
  logic [6:0]      w_seg_nxt;

  assign w_wrap    = (r_div_cnt == DW'(REFRESH_DIV - 1));
  assign w_sel_nxt = w_wrap ? (r_sel + 2'd1) : r_sel;

  // Outputs are driven from the upcoming slot so an/seg/dp
  // move on the same edge as digit_sel.
  always_comb begin
    w_nib = w_o_ones;
    unique case (w_sel_nxt)
      2'd3:    w_nib = w_x_tens;
      2'd2:    w_nib = w_x_ones;
      2'd1:    w_nib = w_o_tens;
      default: w_nib = w_o_ones;
    endcase
  end

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    case (w_nib)
      4'd0:    w_seg_nxt = SEG_0;
      4'd1:    w_seg_nxt = SEG_1;
      4'd2:    w_seg_nxt = SEG_2;
      4'd3:    w_seg_nxt = SEG_3;
      4'd4:    w_seg_nxt = SEG_4;
      4'd5:    w_seg_nxt = SEG_5;
      4'd6:    w_seg_nxt = SEG_6;
      4'd7:    w_seg_nxt = SEG_7;
      4'd8:    w_seg_nxt = SEG_8;
      4'd9:    w_seg_nxt = SEG_9;
      default: w_seg_nxt = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_sel     <= 2'd0;
      r_an      <= 4'b1110;
      r_seg     <= SEG_0;
      r_dp      <= 1'b1;
    end else begin
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + DW'(1);
      r_sel     <= w_sel_nxt;
      r_an      <= ~(AN_W'(1) << w_sel_nxt);
      r_seg     <= w_seg_nxt;
      r_dp      <= (w_sel_nxt != 2'd2);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: per-cycle scoreboard plus
// table of game sequences checked on the scanned display.
module tb_score_display;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic [2:0] game_status;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic [7:0] draws;

  score_display #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .game_status (game_status),
    .seg         (seg),
    .an          (an),
    .dp          (dp),
    .draws       (draws)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segtab [10];
  initial begin
    segtab[0] = 7'b1000000;
    segtab[1] = 7'b1111001;
    segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000;
    segtab[4] = 7'b0011001;
    segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010;
    segtab[7] = 7'b1111000;
    segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;
  end

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  int mx, mo, md, mdiv, msel;
  bit marmed;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic int nib_of(input int sel);
    case (sel)
      3:       return mx / 10;
      2:       return mx % 10;
      1:       return mo / 10;
      default: return mo % 10;
    endcase
  endfunction

  // Model one clock edge, return outputs seen after it
  function automatic exp_t model_step(input logic [2:0] st,
                                      input logic r);
    exp_t e;
    int   nsel;
    if (r) begin
      mx = 0; mo = 0; md = 0; marmed = 0;
      mdiv = 0; msel = 0;
      e.an  = 4'b1110;
      e.seg = segtab[0];
      e.dp  = 1'b1;
      e.d   = 8'd0;
      return e;
    end
    nsel = (mdiv == DIV - 1) ? (msel + 1) % 4 : msel;
    mdiv = (mdiv == DIV - 1) ? 0 : mdiv + 1;
    msel = nsel;
    e.an  = ~(4'b0001 << nsel);
    e.seg = segtab[nib_of(nsel)];
    e.dp  = (nsel != 2);
    if (!marmed) begin
      if (st == 3'd0) marmed = 1;
    end else if (st == 3'd1) begin
      if (mx < 99) mx++;
      marmed = 0;
    end else if (st == 3'd2) begin
      if (mo < 99) mo++;
      marmed = 0;
    end else if (st == 3'd3) begin
      if (md < 255) md++;
      marmed = 0;
    end
    e.d = md[7:0];
    return e;
  endfunction

  task automatic cyc(input logic [2:0] st, input logic r);
    exp_t e;
    game_status = st;
    rst         = r;
    q.push_back(model_step(st, r));
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    chk("an",    an,    e.an);
    chk("seg",   seg,   e.seg);
    chk("dp",    dp,    e.dp);
    chk("draws", draws, e.d);
  endtask

  // Scan all four digit slots and compare with fixed scores
  task automatic scan_check(input int ex, input int eo,
                            input int ed, input string nm);
    logic [6:0] got [4];
    logic [6:0] want [4];
    for (int i = 0; i < 4; i++) got[i] = 7'bx;
    want[3] = segtab[ex / 10];
    want[2] = segtab[ex % 10];
    want[1] = segtab[eo / 10];
    want[0] = segtab[eo % 10];
    cyc(3'd4, 1'b0);
    for (int k = 0; k < 4 * DIV; k++) begin
      cyc(3'd4, 1'b0);
      for (int i = 0; i < 4; i++)
        if (an == ~(4'b0001 << i)) got[i] = seg;
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s digit%0d", nm, i), got[i], want[i]);
    chk($sformatf("%s draws", nm), draws, ed);
  endtask

  typedef struct {
    logic       r;
    logic [2:0] s1;
    int         n1;
    logic [2:0] s2;
    int         n2;
    int         reps;
    int         ex;
    int         eo;
    int         ed;
    string      nm;
  } vec_t;

  localparam int NV = 12;
  vec_t v [NV];

  initial begin
    rst = 1'b1;
    game_status = 3'd0;

    v[0]  = '{1'b1, 3'd1, 20, 3'd1, 0, 1,  0,  0, 0,   "no_play"};
    v[1]  = '{1'b0, 3'd0, 3,  3'd1, 50, 1, 1,  0, 0,   "xwin_hold"};
    v[2]  = '{1'b0, 3'd0, 1,  3'd2, 1, 1,  1,  1, 0,   "owin"};
    v[3]  = '{1'b1, 3'd0, 1,  3'd1, 1, 9,  9,  0, 0,   "x9"};
    v[4]  = '{1'b0, 3'd0, 1,  3'd1, 1, 1,  10, 0, 0,   "carry10"};
    v[5]  = '{1'b0, 3'd0, 1,  3'd1, 1, 2,  12, 0, 0,   "x12"};
    v[6]  = '{1'b0, 3'd0, 1,  3'd1, 2, 93, 99, 0, 0,   "x_sat"};
    v[7]  = '{1'b0, 3'd0, 1,  3'd3, 1, 260, 99, 0, 255, "d_sat"};
    v[8]  = '{1'b1, 3'd0, 1,  3'd1, 1, 1,  1,  0, 0,   "x1"};
    v[9]  = '{1'b0, 3'd2, 3,  3'd4, 1, 1,  1,  0, 0,   "term2term"};
    v[10] = '{1'b0, 3'd0, 1,  3'd5, 6, 1,  1,  0, 0,   "code5"};
    v[11] = '{1'b0, 3'd7, 6,  3'd3, 1, 1,  1,  0, 1,   "code7_armed"};

    for (int i = 0; i < NV; i++) begin
      if (v[i].r) cyc(v[i].s1, 1'b1);
      for (int r = 0; r < v[i].reps; r++) begin
        for (int k = 0; k < v[i].n1; k++) cyc(v[i].s1, 1'b0);
        for (int k = 0; k < v[i].n2; k++) cyc(v[i].s2, 1'b0);
      end
      scan_check(v[i].ex, v[i].eo, v[i].ed, v[i].nm);
    end

    // Reset mid-refresh with scores 07/03
    cyc(3'd4, 1'b1);
    for (int k = 0; k < 7; k++) begin
      cyc(3'd0, 1'b0);
      cyc(3'd1, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(3'd0, 1'b0);
      cyc(3'd2, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(3'd0, 1'b0);
      cyc(3'd3, 1'b0);
    end
    scan_check(7, 3, 2, "pre_rst");
    cyc(3'd4, 1'b0);
    cyc(3'd1, 1'b1);
    chk("rst an",    an,    4'b1110);
    chk("rst seg",   seg,   7'b1000000);
    chk("rst dp",    dp,    1'b1);
    chk("rst draws", draws, 8'd0);
    for (int k = 0; k < 5; k++) cyc(3'd1, 1'b0);
    scan_check(0, 0, 0, "post_rst_noplay");
    cyc(3'd0, 1'b0);
    cyc(3'd1, 1'b0);
    scan_check(1, 0, 0, "post_rst_play");

    chk("queue empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
